// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory handshake signals around the unified-memory arbiter.
// The slave modport is the arbiter's view; master is the core/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ireq_valid;
  logic [ADDR_W-1:0] ireq_addr;
  logic              iresp_valid;
  logic [DATA_W-1:0] iresp_data;

  logic              dreq_valid;
  logic              dreq_write;
  logic [ADDR_W-1:0] dreq_addr;
  logic [DATA_W-1:0] dreq_wdata;
  logic              dresp_valid;
  logic [DATA_W-1:0] dresp_data;

  logic              mem_valid;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ireq_valid, ireq_addr,
    input  dreq_valid, dreq_write, dreq_addr, dreq_wdata,
    input  mem_ready, mem_rdata,
    output iresp_valid, iresp_data,
    output dresp_valid, dresp_data,
    output mem_valid, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output ireq_valid, ireq_addr,
    output dreq_valid, dreq_write, dreq_addr, dreq_wdata,
    output mem_ready, mem_rdata,
    input  iresp_valid, iresp_data,
    input  dresp_valid, dresp_data,
    input  mem_valid, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and data requests onto one single-ported memory.
// Data wins ties, but a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_port_arbiter_if.slave     bus
);

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  starve_cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              write_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              mem_valid_reg;
  logic              iresp_valid_reg;
  logic              dresp_valid_reg;
  logic [DATA_W-1:0] iresp_data_reg;
  logic [DATA_W-1:0] dresp_data_reg;
  logic              grant_fetch;

  // Fetch is granted when it is alone, or when data has used up its run of grants.
  assign grant_fetch = bus.ireq_valid &&
                       (!bus.dreq_valid || (STARVE_LIMIT != 0 && starve_cnt_reg == LIMIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      starve_cnt_reg  <= '0;
      addr_reg        <= '0;
      write_reg       <= 1'b0;
      wdata_reg       <= '0;
      mem_valid_reg   <= 1'b0;
      iresp_valid_reg <= 1'b0;
      dresp_valid_reg <= 1'b0;
      iresp_data_reg  <= '0;
      dresp_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_fetch) begin
            state_reg      <= BUSY_I;
            addr_reg       <= bus.ireq_addr;
            write_reg      <= 1'b0;
            wdata_reg      <= '0;
            starve_cnt_reg <= '0;
            mem_valid_reg  <= 1'b1;
          end else if (bus.dreq_valid) begin
            state_reg     <= BUSY_D;
            addr_reg      <= bus.dreq_addr;
            write_reg     <= bus.dreq_write;
            wdata_reg     <= bus.dreq_wdata;
            mem_valid_reg <= 1'b1;
            // Only count data grants that actually made a fetch wait.
            if (!bus.ireq_valid)
              starve_cnt_reg <= '0;
            else if (starve_cnt_reg != LIMIT)
              starve_cnt_reg <= starve_cnt_reg + 1'b1;
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.mem_ready) begin
            state_reg     <= RESP;
            mem_valid_reg <= 1'b0;
            write_reg     <= 1'b0;
            if (state_reg == BUSY_I) begin
              iresp_valid_reg <= 1'b1;
              iresp_data_reg  <= bus.mem_rdata;
            end else begin
              dresp_valid_reg <= 1'b1;
              dresp_data_reg  <= write_reg ? '0 : bus.mem_rdata;
            end
          end
        end
        RESP: begin
          state_reg       <= IDLE;
          iresp_valid_reg <= 1'b0;
          dresp_valid_reg <= 1'b0;
          iresp_data_reg  <= '0;
          dresp_data_reg  <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.mem_valid   = mem_valid_reg;
  assign bus.mem_write   = write_reg;
  assign bus.mem_addr    = addr_reg;
  assign bus.mem_wdata   = wdata_reg;
  assign bus.iresp_valid = iresp_valid_reg;
  assign bus.iresp_data  = iresp_data_reg;
  assign bus.dresp_valid = dresp_valid_reg;
  assign bus.dresp_data  = dresp_data_reg;

endmodule
